// File: rtl/bcd_to_binary_seq.sv
// Sequential three-digit BCD to binary converter using reverse double-dabble.
// One shift-and-correct iteration per clock; ten iterations per valid request.
module bcd_to_binary_seq (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [3:0] i_hunds,
  input  logic [3:0] i_tens,
  input  logic [3:0] i_units,
  output logic [9:0] o_result,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [21:0] r_sr;
  logic [9:0]  r_result;
  logic        r_busy;
  logic        r_done;
  logic        r_error;

  logic        w_bad;
  logic [21:0] w_shifted;
  logic [21:0] w_next;

  assign w_bad = (i_hunds > 4'd9) || (i_tens > 4'd9) || (i_units > 4'd9);

  // Rotate rather than zero-fill: binary bit 0 is still empty before every
  // iteration, so this is identical to a plain right shift.
  assign w_shifted = {r_sr[0], r_sr[21:1]};
  assign w_next[9:0] = w_shifted[9:0];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_nibble_fix
      assign w_next[10+4*gi +: 4] = (w_shifted[10+4*gi +: 4] >= 4'd8)
                                    ? (w_shifted[10+4*gi +: 4] - 4'd3)
                                    : w_shifted[10+4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_sr     <= 22'd0;
      r_result <= 10'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_sr    <= {i_hunds, i_tens, i_units, 10'd0};
            r_error <= w_bad;
            r_busy  <= 1'b1;
            if (w_bad) begin
              r_result <= 10'd0;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_cnt   <= 4'd0;
              r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          r_sr <= w_next;
          if (r_cnt == 4'd9) begin
            r_result <= w_next[9:0];
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_result = r_result;
  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_error  = r_error;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: directed cases, reset abort,
// exhaustive valid sweep and random (possibly invalid) digits vs. arithmetic model.
module tb_bcd_to_binary_seq;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_start;
  logic [3:0] i_hunds;
  logic [3:0] i_tens;
  logic [3:0] i_units;
  logic [9:0] o_result;
  logic       o_busy;
  logic       o_done;
  logic       o_error;

  int total;
  int bad;
  int prev_res;

  bcd_to_binary_seq dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_start  (i_start),
    .i_hunds  (i_hunds),
    .i_tens   (i_tens),
    .i_units  (i_units),
    .o_result (o_result),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_error  (o_error)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Starts at a negedge in IDLE; returns at the negedge of the IDLE cycle after DONE.
  task automatic run_conv(input int h, input int t, input int u,
                          input bit junk, input bit hold,
                          input int h2, input int t2, input int u2);
    int  exp_res;
    bit  exp_err;
    int  off;
    int  busy_n;
    bit  hold_ok;
    bit  seen;
    exp_err = (h > 9) || (t > 9) || (u > 9);
    exp_res = exp_err ? 0 : 100 * h + 10 * t + u;
    i_hunds = 4'(h);
    i_tens  = 4'(t);
    i_units = 4'(u);
    i_start = 1'b1;
    @(posedge i_clk);
    off = -1; busy_n = 0; hold_ok = 1'b1; seen = 1'b0;
    for (int n = 0; n < 30 && !seen; n++) begin
      @(negedge i_clk);
      off = n;
      if (o_busy) busy_n++;
      if (o_done) begin
        seen = 1'b1;
        if (hold) begin
          i_start = 1'b1;
        end else if (junk) begin
          i_start = 1'b1;
          i_hunds = 4'($urandom_range(0, 15));
          i_tens  = 4'($urandom_range(0, 15));
          i_units = 4'($urandom_range(0, 15));
        end else begin
          i_start = 1'b0;
        end
      end else begin
        if (int'(o_result) != prev_res || o_error) hold_ok = 1'b0;
        if (hold) begin
          i_start = 1'b1;
          i_hunds = 4'(h2);
          i_tens  = 4'(t2);
          i_units = 4'(u2);
        end else if (junk) begin
          i_start = 1'($urandom_range(0, 1));
          i_hunds = 4'($urandom_range(0, 15));
          i_tens  = 4'($urandom_range(0, 15));
          i_units = 4'($urandom_range(0, 15));
        end else begin
          i_start = 1'b0;
        end
      end
    end
    check_val("done_seen", int'(seen), 1);
    check_val("done_latency", off, exp_err ? 0 : 10);
    check_val("busy_cycles", busy_n, exp_err ? 1 : 11);
    check_val("result", int'(o_result), exp_res);
    check_val("error", int'(o_error), int'(exp_err));
    check_val("hold_during_shift", int'(hold_ok), 1);
    $display("conv h=%0d t=%0d u=%0d -> result=%0d error=%0d latency=%0d busy=%0d (exp %0d/%0d)",
             h, t, u, o_result, o_error, off, busy_n, exp_res, exp_err);
    prev_res = exp_res;
    @(negedge i_clk);
    if (!hold && !junk) i_start = 1'b0;
    check_val("idle_done_low", int'(o_done), 0);
    check_val("idle_busy_low", int'(o_busy), 0);
    check_val("idle_result_hold", int'(o_result), exp_res);
  endtask

  initial begin
    int dones;
    total = 0; bad = 0; prev_res = 0;
    i_rst_n = 1'b0; i_start = 1'b0;
    i_hunds = 4'd0; i_tens = 4'd0; i_units = 4'd0;
    repeat (2) @(negedge i_clk);
    check_val("rst_result", int'(o_result), 0);
    check_val("rst_busy", int'(o_busy), 0);
    check_val("rst_done", int'(o_done), 0);
    check_val("rst_error", int'(o_error), 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    run_conv(2, 5, 5, 1'b0, 1'b0, 0, 0, 0);
    run_conv(9, 9, 9, 1'b0, 1'b0, 0, 0, 0);
    run_conv(0, 0, 0, 1'b0, 1'b0, 0, 0, 0);
    run_conv(1, 10, 1, 1'b0, 1'b0, 0, 0, 0);
    run_conv(3, 1, 4, 1'b0, 1'b0, 0, 0, 0);
    run_conv(1, 2, 3, 1'b0, 1'b1, 4, 5, 6);
    run_conv(4, 5, 6, 1'b0, 1'b0, 0, 0, 0);

    // Reset in the middle of a conversion: edge k+6 performs iteration 5.
    i_hunds = 4'd7; i_tens = 4'd7; i_units = 4'd7; i_start = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (6) @(posedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    check_val("abort_result", int'(o_result), 0);
    check_val("abort_busy", int'(o_busy), 0);
    check_val("abort_done", int'(o_done), 0);
    check_val("abort_error", int'(o_error), 0);
    dones = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge i_clk);
      if (o_done) dones++;
    end
    i_rst_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge i_clk);
      if (o_done) dones++;
    end
    check_val("abort_no_done", dones, 0);
    prev_res = 0;
    run_conv(0, 4, 2, 1'b0, 1'b0, 0, 0, 0);

    for (int i = 0; i < 1000; i++)
      run_conv(i / 100, (i / 10) % 10, i % 10, bit'(i % 2), 1'b0, 0, 0, 0);

    for (int i = 0; i < 150; i++)
      run_conv(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 15)), 1'b1, 1'b0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
